apb_master_arbiter: RTL

Two-requester front end for the APB bus: arbitrates round-robin between two command sources and runs the APB master sequence (IDLE/SETUP/ACCESS) on the bus. Address bit 8 selects slave 1 or slave 2. The block sits between the system-side requesters and the two APB slaves. It returns read data, error status and a one-cycle done pulse to whichever requester was granted.

---
 rtl/apb_master_arbiter_pkg.sv | 17 +
 rtl/apb_rr_arbiter.sv | 33 +++
 rtl/apb_master_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/apb_master_arbiter_pkg.sv
// Shared types and constants for the two-requester APB master front end.
package apb_arb_pkg;

  // Bus sequencer phases: nothing in flight, address phase, enable/wait phase
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_WIDTH = 9;
  localparam int APB_DATA_WIDTH = 8;

  // The address MSB picks slave 1 (bit clear) or slave 2 (bit set)
  localparam int SLAVE_SEL_BIT = APB_ADDR_WIDTH - 1;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin arbiter. The grant is combinational from the eligible
// vector; the last winner is remembered only when the caller takes the grant.
module apb_rr_arbiter (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_eligible,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  logic r_lastGrant;

  // A lone requester always wins; a tie goes to whoever did not win last
  always_comb begin
    o_grant = 2'b00;
    case (i_eligible)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_lastGrant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  // Starting from "1 won last" lets requester 0 take the first tie after reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lastGrant <= 1'b1;
    end else if (i_advance && (o_grant != 2'b00)) begin
      r_lastGrant <= o_grant[1];
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: picks a requester round-robin, runs the
// IDLE/SETUP/ACCESS sequence toward slave 1 or 2 (address MSB), and returns
// a one-cycle done pulse with read data and error status. Every output is a
// flop; the bus-side registers double as the latched request.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [DATA_WIDTH-1:0] req_wdata0,
  input  logic [DATA_WIDTH-1:0] req_wdata1,
  output logic [1:0]            req_done,
  output logic                  req_err,
  output logic [DATA_WIDTH-1:0] req_rdata,
  output logic                  PSEL1,
  output logic                  PSEL2,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  localparam int SEL_BIT = ADDR_WIDTH - 1;
  localparam int CNT_W   = $clog2(TIMEOUT);

  apb_state_e            r_state, w_nextState;
  logic [1:0]            r_psel, w_pselNxt;
  logic                  r_penable, w_penableNxt;
  logic                  r_pwrite, w_pwriteNxt;
  logic [ADDR_WIDTH-1:0] r_paddr, w_paddrNxt;
  logic [DATA_WIDTH-1:0] r_pwdata, w_pwdataNxt;
  logic                  r_gidx, w_gidxNxt;
  logic [CNT_W-1:0]      r_cnt, w_cntNxt;
  logic [1:0]            r_done, w_doneNxt;
  logic                  r_err, w_errNxt;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdataNxt;

  logic [1:0]            w_eligible;
  logic [1:0]            w_grant;
  logic                  w_advance;
  logic [ADDR_WIDTH-1:0] w_addrSel;
  logic [DATA_WIDTH-1:0] w_wdataSel;

  // A requester that is seeing its done pulse this cycle may still show
  // valid; it must not be granted again off that stale request.
  assign w_eligible = req_valid & ~r_done;
  assign w_addrSel  = w_grant[1] ? req_addr1  : req_addr0;
  assign w_wdataSel = w_grant[1] ? req_wdata1 : req_wdata0;

  apb_rr_arbiter u_arbiter (
    .i_clk      (PCLK),
    .i_reset    (PRESET),
    .i_eligible (w_eligible),
    .i_advance  (w_advance),
    .o_grant    (w_grant)
  );

  // Next state and next register values for the bus sequencer
  always_comb begin
    w_nextState  = r_state;
    w_pselNxt    = r_psel;
    w_penableNxt = r_penable;
    w_pwriteNxt  = r_pwrite;
    w_paddrNxt   = r_paddr;
    w_pwdataNxt  = r_pwdata;
    w_gidxNxt    = r_gidx;
    w_cntNxt     = r_cnt;
    w_doneNxt    = 2'b00;
    w_errNxt     = 1'b0;
    w_rdataNxt   = '0;
    w_advance    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_grant != 2'b00) begin
          w_advance    = 1'b1;
          w_gidxNxt    = w_grant[1];
          w_pwriteNxt  = req_write[w_grant[1]];
          w_paddrNxt   = w_addrSel;
          w_pwdataNxt  = w_wdataSel;
          w_pselNxt    = w_addrSel[SEL_BIT] ? 2'b10 : 2'b01;
          w_penableNxt = 1'b0;
          w_nextState  = SETUP;
        end
      end
      SETUP: begin
        w_penableNxt = 1'b1;
        w_nextState  = ACCESS;
      end
      ACCESS: begin
        if (PREADY || (r_cnt == CNT_W'(TIMEOUT - 1))) begin
          w_doneNxt    = r_gidx ? 2'b10 : 2'b01;
          w_errNxt     = PREADY ? PSLVERR : 1'b1;
          w_rdataNxt   = (PREADY && !r_pwrite) ? PRDATA : '0;
          w_pselNxt    = 2'b00;
          w_penableNxt = 1'b0;
          w_pwriteNxt  = 1'b0;
          w_paddrNxt   = '0;
          w_pwdataNxt  = '0;
          w_cntNxt     = '0;
          w_nextState  = IDLE;
        end else begin
          w_cntNxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the bus without a done pulse
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state   <= IDLE;
      r_psel    <= 2'b00;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_gidx    <= 1'b0;
      r_cnt     <= '0;
      r_done    <= 2'b00;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_nextState;
      r_psel    <= w_pselNxt;
      r_penable <= w_penableNxt;
      r_pwrite  <= w_pwriteNxt;
      r_paddr   <= w_paddrNxt;
      r_pwdata  <= w_pwdataNxt;
      r_gidx    <= w_gidxNxt;
      r_cnt     <= w_cntNxt;
      r_done    <= w_doneNxt;
      r_err     <= w_errNxt;
      r_rdata   <= w_rdataNxt;
    end
  end

  assign PSEL1     = r_psel[0];
  assign PSEL2     = r_psel[1];
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign req_done  = r_done;
  assign req_err   = r_err;
  assign req_rdata = r_rdata;

endmodule
